uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Packet-level round-robin arbiter sharing the SoC's single UART transmitter byte interface between two requesters: req0 (CPU peripheral store path) and req1 (debug trace path emitting PC/ACC snapshots).
- Grant is locked for a whole packet, so bytes from the two sources never interleave on the UART TX line.
- A timeout reclaims the grant from a requester that stalls mid-packet.
- Sits between the requesters and the UART TX byte-level valid/ready input.

Parameters:
- DATA_W, 8, byte width on all data ports.
- TIMEOUT, 255, idle cycles a granted owner may hold the grant mid-packet without presenting data; must be at least 1.
- CNT_W, 8, width of the per-requester completed-packet counters.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- req0_valid  input  1  requester 0 presents a byte.
- req0_data  input  DATA_W  requester 0 byte.
- req0_last  input  1  byte is last of packet, qualified by req0_valid.
- req0_ready  output  1  requester 0 byte accepted this cycle when valid is also high.
- req1_valid, req1_data, req1_last, req1_ready: same as req0, for requester 1.
- tx_valid  output  1  byte offered to UART TX.
- tx_data  output  DATA_W  byte to UART TX.
- tx_ready  input  1  UART TX accepts byte.
- gnt  output  2  registered one-hot owner; 00 when idle.
- busy  output  1  high while any grant is held.
- timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout.
- pkt_cnt0  output  CNT_W  packets completed by req0 with last set; wraps.
- pkt_cnt1  output  CNT_W  same for req1.

Behaviour:
- Reset values, applied on the first rising edge with rst=1:
  - state=IDLE, gnt=00, busy=0, timeout_pulse=0.
  - pkt_cnt0=pkt_cnt1=0, idle counter=0.
  - last_owner=1, so req0 wins the first tie.
- Reset mid-packet discards ownership immediately. The partial packet is not counted, and no timeout_pulse is generated.
- States:
  - IDLE, LOCK0, LOCK1.
  - gnt=01 in LOCK0, 10 in LOCK1; busy equals gnt[0]|gnt[1].
- IDLE:
  - tx_valid=0, both readies 0.
  - If exactly one reqN_valid is high, go to LOCKN next cycle.
  - If both are high, go to the requester that is not last_owner.
  - Arbitration latency is 1 cycle; the first byte can transfer at the earliest in the cycle after the request is seen.
- LOCKn datapath, combinational passthrough:
  - tx_valid=reqn_valid, tx_data=reqn_data, reqn_ready=tx_ready.
  - The non-owner's ready is 0.
  - A transfer occurs when reqn_valid and tx_ready are both high.
- Packet end:
  - A transfer with reqn_last=1 sends the FSM to IDLE next cycle, sets last_owner=n and increments pkt_cntn (modulo 2^CNT_W).
  - No back-to-back grant: IDLE always lasts at least 1 cycle, giving the other requester a fair turn.
- Timeout:
  - In LOCKn the idle counter increments each cycle reqn_valid=0 and clears on any cycle reqn_valid=1.
  - A tx_ready=0 stall does not count as idle, as long as valid is high.
  - When the counter reaches TIMEOUT-1 with reqn_valid still 0, the next edge goes to IDLE, sets last_owner=n and asserts timeout_pulse for exactly one cycle. pkt_cntn is not incremented.
  - The counter saturates and is cleared on every entry to LOCK.
- Simultaneous events:
  - A last-byte transfer and timeout cannot coincide, since valid=1 clears the counter.
  - A request arriving in the cycle the FSM leaves LOCK is evaluated in the following IDLE cycle.
- tx_data is don't-care when tx_valid=0 but must be driven; use the owner's data or 0 in IDLE.
- Counter widths: the idle counter is ceil(log2(TIMEOUT+1)) bits; no overflow is possible.

Decomposition:
- Shared package soc_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_LOCK0=2'd1, ST_LOCK1=2'd2.
  - default DATA_W=8.
- One natural sub-module, arb_idle_timer:
  - loadable clear and count-enable.
  - saturating counter with a registered `expired` output.
  - parameterised by TIMEOUT.
- The FSM, mux and packet counters stay in uart_tx_arbiter.

Test Plan:
- Release rst. req0 sends 3-byte packet 0x41,0x42,0x43 (last on 0x43), tx_ready=1 -> gnt=01 one cycle after valid; tx_data sequence 41,42,43 on consecutive cycles; then gnt=00; pkt_cnt0=1.
- Both requesters valid in the same cycle after reset -> req0 granted first; after its packet ends, req1 granted after exactly 1 IDLE cycle; this alternates over 4 packets, ending with pkt_cnt0=2, pkt_cnt1=2.
- req1 owns grant; hold tx_ready=0 for 300 cycles with req1_valid=1 -> no timeout, req0_ready stays 0; release tx_ready -> packet completes normally.
- TIMEOUT=255; req0 sends one non-last byte, then drops valid -> timeout_pulse high for 1 cycle after 255 idle cycles; gnt=00; pkt_cnt0 unchanged; pending req1 granted next.
- Assert rst mid-packet after 2 of 4 bytes -> next cycle gnt=00, tx_valid=0, counters 0. After release with both valid, req0 wins.
- Run 256 single-byte req1 packets -> pkt_cnt1 wraps to 0; no byte ever appears on tx_data unless exactly one gnt bit is set.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared encodings for the UART TX arbiter slice.
package soc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  localparam int unsigned DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StLock0 = ST_LOCK0,
    StLock1 = ST_LOCK1
  } arb_state_e;

endpackage

// File: rtl/arb_idle_timer.sv
// Saturating idle-cycle counter; expired is high while the count sits at TIMEOUT-1.
module arb_idle_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            expired_q, expired_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CntW'(TIMEOUT))) begin
      cnt_d = cnt_q + CntW'(1);
    end
    // Registered from the next count so the flag lines up with the count it describes.
    expired_d = (cnt_d == CntW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART TX byte port between two requesters,
// with an idle timeout that reclaims the grant from a stalled owner.
module uart_tx_arbiter
  import soc_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              timeout_pulse,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  arb_state_e       state_q, state_d;
  logic             last_owner_q, last_owner_d;
  logic             timeout_pulse_q, timeout_pulse_d;
  logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;

  logic              owner;
  logic              own_valid;
  logic              own_last;
  logic [DATA_W-1:0] own_data;
  logic              timer_clr;
  logic              timer_en;
  logic              timer_expired;

  // Owner index is only meaningful in a lock state.
  assign owner     = (state_q == StLock1);
  assign own_valid = owner ? req1_valid : req0_valid;
  assign own_last  = owner ? req1_last : req0_last;
  assign own_data  = owner ? req1_data : req0_data;

  arb_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(timer_expired)
  );

  always_comb begin
    state_d         = state_q;
    last_owner_d    = last_owner_q;
    timeout_pulse_d = 1'b0;
    pkt_cnt0_d      = pkt_cnt0_q;
    pkt_cnt1_d      = pkt_cnt1_q;
    tx_valid        = 1'b0;
    tx_data         = '0;
    req0_ready      = 1'b0;
    req1_ready      = 1'b0;
    timer_clr       = 1'b1;
    timer_en        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req0_valid && req1_valid) begin
          state_d = last_owner_q ? StLock0 : StLock1;
        end else if (req0_valid) begin
          state_d = StLock0;
        end else if (req1_valid) begin
          state_d = StLock1;
        end
      end
      StLock0, StLock1: begin
        tx_valid   = own_valid;
        tx_data    = own_data;
        req0_ready = ~owner & tx_ready;
        req1_ready = owner & tx_ready;
        // A tx_ready stall with valid high is not idle time.
        timer_clr  = own_valid;
        timer_en   = ~own_valid;
        if (own_valid && tx_ready && own_last) begin
          state_d      = StIdle;
          last_owner_d = owner;
          if (owner) begin
            pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
          end else begin
            pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
          end
        end else if (!own_valid && timer_expired) begin
          state_d         = StIdle;
          last_owner_d    = owner;
          timeout_pulse_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      last_owner_q    <= 1'b1;
      timeout_pulse_q <= 1'b0;
      pkt_cnt0_q      <= '0;
      pkt_cnt1_q      <= '0;
    end else begin
      state_q         <= state_d;
      last_owner_q    <= last_owner_d;
      timeout_pulse_q <= timeout_pulse_d;
      pkt_cnt0_q      <= pkt_cnt0_d;
      pkt_cnt1_q      <= pkt_cnt1_d;
    end
  end

  assign gnt           = {state_q == StLock1, state_q == StLock0};
  assign busy          = gnt[0] | gnt[1];
  assign timeout_pulse = timeout_pulse_q;
  assign pkt_cnt0      = pkt_cnt0_q;
  assign pkt_cnt1      = pkt_cnt1_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: packet-level reference model plus directed literal checks.
module tb_uart_tx_arbiter;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned CNT_W   = 8;

  logic              clk;
  logic              rst;
  logic              req0_valid, req0_last, req0_ready;
  logic              req1_valid, req1_last, req1_ready;
  logic [DATA_W-1:0] req0_data, req1_data, tx_data;
  logic              tx_valid, tx_ready, busy, timeout_pulse;
  logic [1:0]        gnt;
  logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;

  uart_tx_arbiter #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_last    (req0_last),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_last    (req1_last),
    .req1_ready   (req1_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .gnt          (gnt),
    .busy         (busy),
    .timeout_pulse(timeout_pulse),
    .pkt_cnt0     (pkt_cnt0),
    .pkt_cnt1     (pkt_cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  // Requester byte queues: {last, data}; head is what the requester presents.
  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  int unsigned pv0 = 100, pv1 = 100, tr_pct = 100;
  bit          check_en = 0;

  // Packet-level model: who owns the port, idle cycles so far, counts.
  int m_owner = -1;
  int m_idle  = 0;
  int m_last  = 1;
  int m_cnt0  = 0;
  int m_cnt1  = 0;
  bit m_pulse = 0;

  logic [7:0] tx_log[$];
  logic [1:0] gnt_log[$];
  int         gap_log[$];
  int         idle_run = 0;
  logic [1:0] prev_gnt = 2'b00;
  int         pulse_cnt = 0;

  logic [1:0] e_gnt;
  logic       v_own, l_own;
  logic [7:0] d_own;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_pkt(input int r, input int len);
    logic [8:0] e;
    for (int i = 0; i < len; i++) begin
      e = {(i == len - 1), 8'($urandom)};
      if (r == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && m_owner < 0) done = 1;
      else tick();
    end
    chk(name, done, 1);
  endtask

  task automatic wait_gnt(input string name, input logic [1:0] want, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (gnt === want) seen = 1;
      else tick();
    end
    chk(name, seen, 1);
  endtask

  // Requester and UART-side drivers.
  initial begin
    req0_valid = 0; req0_data = '0; req0_last = 0;
    req1_valid = 0; req1_data = '0; req1_last = 0;
    tx_ready   = 0;
    forever begin
      @(posedge clk);
      #1;
      req0_valid = (q0.size() != 0) && ($urandom_range(99) < pv0);
      {req0_last, req0_data} = (q0.size() != 0) ? q0[0] : 9'h000;
      req1_valid = (q1.size() != 0) && ($urandom_range(99) < pv1);
      {req1_last, req1_data} = (q1.size() != 0) ? q1[0] : 9'h000;
      tx_ready = ($urandom_range(99) < tr_pct);
    end
  end

  // Compare against the model, then advance the model by one cycle.
  always @(negedge clk) begin
    if (check_en) begin
      e_gnt = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      v_own = (m_owner == 0) ? req0_valid : (m_owner == 1) ? req1_valid : 1'b0;
      l_own = (m_owner == 0) ? req0_last : req1_last;
      d_own = (m_owner == 0) ? req0_data : req1_data;
      chk("gnt", gnt, e_gnt);
      chk("busy", busy, m_owner >= 0);
      chk("timeout_pulse", timeout_pulse, m_pulse);
      chk("tx_valid", tx_valid, v_own);
      chk("req0_ready", req0_ready, (m_owner == 0) && tx_ready);
      chk("req1_ready", req1_ready, (m_owner == 1) && tx_ready);
      chk("pkt_cnt0", pkt_cnt0, m_cnt0);
      chk("pkt_cnt1", pkt_cnt1, m_cnt1);
      if (v_own) chk("tx_data", tx_data, d_own);
      if (tx_valid === 1'b1) chk("onehot_gnt", $onehot(gnt), 1);

      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      if (timeout_pulse) pulse_cnt++;
      if (gnt != 2'b00 && prev_gnt == 2'b00) begin
        gnt_log.push_back(gnt);
        gap_log.push_back(idle_run);
      end
      idle_run = (gnt == 2'b00) ? idle_run + 1 : 0;
      prev_gnt = gnt;

      if (rst) begin
        m_owner = -1; m_idle = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0; m_pulse = 0;
      end else if (m_owner < 0) begin
        m_pulse = 0;
        m_idle  = 0;
        if (req0_valid && req1_valid) m_owner = 1 - m_last;
        else if (req0_valid) m_owner = 0;
        else if (req1_valid) m_owner = 1;
      end else begin
        m_pulse = 0;
        if (v_own && tx_ready) begin
          if (m_owner == 0 && q0.size() != 0) void'(q0.pop_front());
          if (m_owner == 1 && q1.size() != 0) void'(q1.pop_front());
        end
        if (v_own && tx_ready && l_own) begin
          if (m_owner == 0) m_cnt0 = (m_cnt0 + 1) % (1 << CNT_W);
          else m_cnt1 = (m_cnt1 + 1) % (1 << CNT_W);
          m_last  = m_owner;
          m_owner = -1;
        end else if (v_own) begin
          m_idle = 0;
        end else if (m_idle + 1 == int'(TIMEOUT)) begin
          m_last  = m_owner;
          m_owner = -1;
          m_pulse = 1;
        end else begin
          m_idle++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_seen;
    bit got;
    int pulses_before;

    rst = 1'b1;
    tick();
    tick();
    check_en = 1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_pulse", timeout_pulse, 0);
    chk("rst_cnt0", pkt_cnt0, 0);
    chk("rst_cnt1", pkt_cnt1, 0);
    rst = 1'b0;
    tick();

    // Single 3-byte packet from req0.
    tx_log.delete();
    q0.push_back({1'b0, 8'h41});
    q0.push_back({1'b0, 8'h42});
    q0.push_back({1'b1, 8'h43});
    tick();
    chk("arb_lat_idle", gnt, 2'b00);
    tick();
    chk("arb_lat_gnt", gnt, 2'b01);
    chk("first_byte", tx_data, 8'h41);
    wait_done("p1_done", 50);
    chk("p1_len", tx_log.size(), 3);
    chk("p1_b0", (tx_log.size() > 0) ? tx_log[0] : 8'hxx, 8'h41);
    chk("p1_b1", (tx_log.size() > 1) ? tx_log[1] : 8'hxx, 8'h42);
    chk("p1_b2", (tx_log.size() > 2) ? tx_log[2] : 8'hxx, 8'h43);
    chk("p1_cnt0", pkt_cnt0, 1);
    chk("p1_gnt", gnt, 2'b00);

    // Both requesters contend right after reset: strict alternation with one idle cycle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    gnt_log.delete();
    gap_log.delete();
    push_pkt(0, 2); push_pkt(0, 2);
    push_pkt(1, 2); push_pkt(1, 2);
    wait_done("p2_done", 100);
    chk("p2_ngrants", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("p2_order", (gnt_log.size() > i) ? gnt_log[i] : 2'bxx, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) chk("p2_gap", (gap_log.size() > i) ? gap_log[i] : -1, 1);
    end
    chk("p2_cnt0", pkt_cnt0, 2);
    chk("p2_cnt1", pkt_cnt1, 2);

    // Long tx_ready stall with valid high must not time out.
    tr_pct = 0;
    push_pkt(1, 3);
    wait_gnt("p3_gnt1", 2'b10, 10);
    push_pkt(0, 2);
    pulses_before = pulse_cnt;
    repeat (300) tick();
    chk("p3_gnt_held", gnt, 2'b10);
    chk("p3_r0_ready", req0_ready, 0);
    chk("p3_no_timeout", pulse_cnt, pulses_before);
    tr_pct = 100;
    wait_done("p3_done", 50);
    chk("p3_cnt0", pkt_cnt0, 3);
    chk("p3_cnt1", pkt_cnt1, 3);

    // req0 stalls mid-packet: timeout after TIMEOUT idle cycles, then pending req1 wins.
    q0.push_back({1'b0, 8'h55});
    wait_gnt("p4_gnt0", 2'b01, 10);
    q1.push_back({1'b1, 8'h66});
    idle_seen = 0;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      if (timeout_pulse === 1'b1) got = 1;
      else if (gnt == 2'b01 && !tx_valid) idle_seen++;
    end
    chk("p4_pulse_seen", got, 1);
    chk("p4_idle_cycles", idle_seen, 255);
    chk("p4_gnt_idle", gnt, 2'b00);
    chk("p4_cnt0", pkt_cnt0, 3);
    tick();
    chk("p4_pulse_width", timeout_pulse, 0);
    chk("p4_gnt1", gnt, 2'b10);
    wait_done("p4_done", 50);
    chk("p4_cnt1", pkt_cnt1, 4);

    // Reset after 2 of 4 bytes.
    tx_log.delete();
    push_pkt(0, 4);
    for (int i = 0; i < 20 && tx_log.size() < 2; i++) tick();
    chk("p5_two_bytes", tx_log.size(), 2);
    rst = 1'b1;
    q0.delete();
    tick();
    chk("p5_gnt", gnt, 2'b00);
    chk("p5_tx_valid", tx_valid, 0);
    chk("p5_pulse", timeout_pulse, 0);
    chk("p5_cnt0", pkt_cnt0, 0);
    chk("p5_cnt1", pkt_cnt1, 0);
    rst = 1'b0;
    q0.push_back({1'b1, 8'h71});
    q1.push_back({1'b1, 8'h72});
    tick();
    chk("p5_idle", gnt, 2'b00);
    tick();
    chk("p5_req0_first", gnt, 2'b01);
    wait_done("p5_done", 50);

    // 256 single-byte req1 packets wrap its counter; random req0 traffic alongside.
    pv0 = 70; pv1 = 70; tr_pct = 60;
    for (int i = 0; i < 256; i++) push_pkt(1, 1);
    for (int i = 0; i < 20; i++) push_pkt(0, $urandom_range(1, 4));
    wait_done("p6_done", 8000);
    chk("p6_cnt1_wrap", pkt_cnt1, 1);
    chk("p6_cnt0", pkt_cnt0, 21);

    // Fully random packets.
    pv0 = 60; pv1 = 60; tr_pct = 60;
    for (int i = 0; i < 30; i++) begin
      push_pkt(0, $urandom_range(1, 5));
      push_pkt(1, $urandom_range(1, 5));
    end
    wait_done("p7_done", 6000);
    chk("p7_cnt0", pkt_cnt0, 51);
    chk("p7_cnt1", pkt_cnt1, 31);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
